ifetch_stage: RTL and testbench
===============================

Name: ifetch_stage

Overview:
- Instruction-fetch stage plus IF/ID latch, directly upstream of decode.
- Holds the PC and selects the next PC (sequential, branch, jump, jump-register).
- Issues instruction-memory reads and presents {instr, pc+4, valid} to decode.
- Honours hazard-unit stalls without refetching, squashes on redirect, and stops fetching on a halt opcode.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded at reset
NOP_WORD, 32'h0000_0000, instruction word inserted on squash/reset
HALT_OP, 6'b111111, opcode (instr[31:26]) that stops fetching

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  synchronous active-low reset, sampled on rising CLK
ihit  in  1  imem read data valid this cycle
imemload  in  32  instruction word from imem
imemREN  out  1  imem read enable
imemaddr  out  32  imem address (= current PC)
stall  in  1  hazard unit: decode cannot accept a new instruction
pc_sel  in  2  redirect select from decode: 0 none, 1 branch, 2 jump, 3 jr
br_addr  in  32  branch target
j_addr  in  32  jump target
jr_addr  in  32  jump-register target
if_instr  out  32  latched instruction to decode
if_pc  out  32  latched pc+4 of that instruction
if_valid  out  1  latched entry is a real instruction
fetch_halted  out  1  high while in HALT state

Behaviour:
- Reset (nRST=0 at a rising edge):
  - pc=PC_INIT, state=FETCH, if_instr=NOP_WORD, if_pc=0, if_valid=0.
  - Hold buffer cleared; fetch_halted=0.
  - imemREN is combinational and equals 1 in the cycle after reset.
- imemaddr = pc at all times. imemREN = (state==FETCH).
- npc = pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0). Word-aligned PCs only; bits[1:0] pass through unchecked.
- redirect = (pc_sel != 0). Target: 1 br_addr, 2 j_addr, 3 jr_addr.
- Priority per edge: reset > redirect > stall > normal.
- States: FETCH, HOLD, HALT.
- FETCH:
  - redirect: pc<=target; latch<=NOP (valid 0); stay FETCH. Any same-cycle ihit data is discarded.
  - ihit & !stall: latch<={imemload, npc, 1}; pc<=npc. If imemload[31:26]==HALT_OP, go to HALT (pc still advances); otherwise stay FETCH.
  - ihit & stall: latch unchanged; hold_buf<=imemload; pc unchanged; go to HOLD.
  - !ihit & !stall: latch<=NOP (valid 0, bubble); pc unchanged.
  - !ihit & stall: latch unchanged.
- HOLD (imemREN=0, no refetch):
  - redirect: pc<=target; discard hold_buf; latch<=NOP; go to FETCH.
  - stall: everything holds.
  - !stall: latch<={hold_buf, npc, 1}; pc<=npc. Go to HALT if hold_buf is the halt opcode, else FETCH.
- HALT (imemREN=0, fetch_halted=1):
  - stall: latch holds.
  - !stall: latch<=NOP (valid 0) after decode consumes the halt.
  - redirect (halt was on a squashed path): pc<=target; latch<=NOP; go to FETCH; fetch_halted drops the next cycle.
  - Only redirect or reset leaves HALT.
- Latency: ihit in cycle N with no stall → if_instr valid in cycle N+1; the next imem request to pc+4 is in cycle N+1.
- Stall for K cycles with an instruction captured → instruction delivered exactly once, on the first cycle after stall drops; no duplicates, no loss.

Test Plan:
- Reset/sequential: nRST low 2 cycles, then ihit=1 every cycle with imemload=0x20010001,0x20020002 → imemaddr 0x0,0x4,0x8; if_instr matches with if_pc 0x4,0x8; if_valid=1 from cycle 2.
- Stall capture: ihit with 0x8C220000 while stall=1 for 3 cycles → imemREN=0 during HOLD, pc stays; after stall drops, if_instr=0x8C220000 exactly once and imemaddr advances by 4.
- Redirect: pc_sel=1, br_addr=0x40 in the same cycle as ihit → latch NOP (valid 0), next imemaddr=0x40. Repeat with pc_sel=3, jr_addr=0x100 while in HOLD → buffer discarded, imemaddr=0x100.
- Halt: fetch 0xFC000000 at pc 0x8 → if_instr=0xFC000000, fetch_halted=1, imemREN=0 for 10+ cycles, if_valid=0 afterwards. Then pc_sel=2, j_addr=0x20 → FETCH resumes at 0x20.
- Wrap and bubbles: set pc to 0xFFFFFFFC via jr → after ihit, imemaddr=0x0. ihit=0 for 2 cycles → if_valid=0 bubbles and pc unchanged.
- Mid-operation reset: nRST=0 while in HOLD → next cycle pc=PC_INIT, if_valid=0, state FETCH, imemREN=1.

Source files
------------

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC register, next-PC select, imem request and IF/ID latch
//   CLK, nRST                       clock, synchronous active-low reset
//   ihit, imemload                  imem response (valid, data)
//   imemREN, imemaddr               imem request (enable, address = pc)
//   stall                           decode cannot accept a new instruction
//   pc_sel, br_addr/j_addr/jr_addr  redirect select and targets
//   if_instr, if_pc, if_valid       IF/ID latch (instruction, pc+4, valid)
//   fetch_halted                    high while fetch is parked on a halt
module ifetch_stage #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] br_addr,
  input  logic [31:0] j_addr,
  input  logic [31:0] jr_addr,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        fetch_halted
);
  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;
  state_t      state;
  logic [31:0] pc, hold_buf, npc, target;
  logic        redirect;
  assign npc          = pc + 32'd4;
  assign redirect     = pc_sel != 2'd0;
  assign target       = pc_sel == 2'd1 ? br_addr : pc_sel == 2'd2 ? j_addr : jr_addr;
  assign imemaddr     = pc;
  assign imemREN      = state == FETCH;
  assign fetch_halted = state == HALT;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc       <= PC_INIT;
      state    <= FETCH;
      hold_buf <= NOP_WORD;
      if_instr <= NOP_WORD;
      if_pc    <= 32'd0;
      if_valid <= 1'b0;
    end else if (redirect) begin
      pc       <= target;
      state    <= FETCH;
      if_instr <= NOP_WORD;
      if_pc    <= 32'd0;
      if_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (ihit && !stall) begin
            if_instr <= imemload;
            if_pc    <= npc;
            if_valid <= 1'b1;
            pc       <= npc;
            state    <= imemload[31:26] == HALT_OP ? HALT : FETCH;
          end else if (ihit) begin
            // park the word so the stalled instruction is delivered without a refetch
            hold_buf <= imemload;
            state    <= HOLD;
          end else if (!stall) begin
            if_instr <= NOP_WORD;
            if_pc    <= 32'd0;
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_instr <= hold_buf;
            if_pc    <= npc;
            if_valid <= 1'b1;
            pc       <= npc;
            state    <= hold_buf[31:26] == HALT_OP ? HALT : FETCH;
          end
        end
        default: begin
          if (!stall) begin
            if_instr <= NOP_WORD;
            if_pc    <= 32'd0;
            if_valid <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed checks of ifetch_stage against hand-computed values
module tb_ifetch_stage;
  logic        CLK = 1'b0, nRST, ihit, stall, imemREN, if_valid, fetch_halted;
  logic [1:0]  pc_sel;
  logic [31:0] imemload, imemaddr, br_addr, j_addr, jr_addr, if_instr, if_pc;
  int          passed = 0, total = 0;

  ifetch_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .stall(stall), .pc_sel(pc_sel), .br_addr(br_addr),
    .j_addr(j_addr), .jr_addr(jr_addr), .if_instr(if_instr), .if_pc(if_pc),
    .if_valid(if_valid), .fetch_halted(fetch_halted)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    nRST = 0; ihit = 0; stall = 0; pc_sel = 0; imemload = 0;
    br_addr = 0; j_addr = 0; jr_addr = 0;
    step(); step();
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_ren", imemREN, 1);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_halted", fetch_halted, 0);

    nRST = 1; ihit = 1; imemload = 32'h20010001;
    step();
    chk("seq1_instr", if_instr, 32'h20010001);
    chk("seq1_pc", if_pc, 32'h4);
    chk("seq1_valid", if_valid, 1);
    chk("seq1_addr", imemaddr, 32'h4);
    imemload = 32'h20020002;
    step();
    chk("seq2_instr", if_instr, 32'h20020002);
    chk("seq2_pc", if_pc, 32'h8);
    chk("seq2_addr", imemaddr, 32'h8);

    stall = 1; imemload = 32'h8C220000;
    step();
    chk("hold_ren", imemREN, 0);
    chk("hold_addr", imemaddr, 32'h8);
    chk("hold_latch", if_instr, 32'h20020002);
    ihit = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_ren_k", imemREN, 0);
      chk("hold_addr_k", imemaddr, 32'h8);
    end
    stall = 0;
    step();
    chk("rel_instr", if_instr, 32'h8C220000);
    chk("rel_pc", if_pc, 32'hC);
    chk("rel_valid", if_valid, 1);
    chk("rel_addr", imemaddr, 32'hC);
    chk("rel_ren", imemREN, 1);
    step();
    chk("rel_once", if_valid, 0);
    chk("bub_addr", imemaddr, 32'hC);

    ihit = 1; imemload = 32'h20030003; pc_sel = 1; br_addr = 32'h40;
    step();
    chk("br_valid", if_valid, 0);
    chk("br_instr", if_instr, 32'h0);
    chk("br_addr", imemaddr, 32'h40);
    pc_sel = 0; stall = 1; imemload = 32'h11111111;
    step();
    chk("jrh_ren", imemREN, 0);
    pc_sel = 3; jr_addr = 32'h100; ihit = 0;
    step();
    chk("jrh_addr", imemaddr, 32'h100);
    chk("jrh_ren2", imemREN, 1);
    chk("jrh_valid", if_valid, 0);
    pc_sel = 0; stall = 0; ihit = 1; imemload = 32'h22222222;
    step();
    chk("jrh_discard", if_instr, 32'h22222222);
    chk("jrh_pc", if_pc, 32'h104);

    pc_sel = 2; j_addr = 32'h8;
    step();
    chk("j8_addr", imemaddr, 32'h8);
    pc_sel = 0; imemload = 32'hFC000000;
    step();
    chk("halt_instr", if_instr, 32'hFC000000);
    chk("halt_valid", if_valid, 1);
    chk("halt_flag", fetch_halted, 1);
    chk("halt_ren", imemREN, 0);
    chk("halt_addr", imemaddr, 32'hC);
    imemload = 32'h20010001;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halted_ren", imemREN, 0);
      chk("halted_flag", fetch_halted, 1);
      chk("halted_valid", if_valid, 0);
      chk("halted_addr", imemaddr, 32'hC);
    end
    pc_sel = 2; j_addr = 32'h20;
    step();
    chk("resume_addr", imemaddr, 32'h20);
    chk("resume_ren", imemREN, 1);
    chk("resume_flag", fetch_halted, 0);
    pc_sel = 0; imemload = 32'h20040004;
    step();
    chk("resume_instr", if_instr, 32'h20040004);
    chk("resume_pc", if_pc, 32'h24);

    pc_sel = 3; jr_addr = 32'hFFFFFFFC;
    step();
    chk("wrap_pre", imemaddr, 32'hFFFFFFFC);
    pc_sel = 0; imemload = 32'h20050005;
    step();
    chk("wrap_addr", imemaddr, 32'h0);
    chk("wrap_pc", if_pc, 32'h0);
    chk("wrap_instr", if_instr, 32'h20050005);
    ihit = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bub_valid", if_valid, 0);
      chk("bub_pc_hold", imemaddr, 32'h0);
    end

    pc_sel = 3; jr_addr = 32'h80; ihit = 1;
    step();
    pc_sel = 0; stall = 1; imemload = 32'h33333333;
    step();
    chk("mr_hold_addr", imemaddr, 32'h80);
    chk("mr_hold_ren", imemREN, 0);
    nRST = 0;
    step();
    chk("mr_addr", imemaddr, 32'h0);
    chk("mr_ren", imemREN, 1);
    chk("mr_valid", if_valid, 0);
    chk("mr_flag", fetch_halted, 0);
    nRST = 1; stall = 0; imemload = 32'h44444444;
    step();
    chk("mr_instr", if_instr, 32'h44444444);
    chk("mr_pc", if_pc, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
